// File: rtl/lab2_proc_pipe_sequencer_pkg.sv
// Shared encodings and per-stage metadata type for the 5-stage pipe sequencer.
// Pure declarations; no timing or flow-control behaviour of its own.
package lab2_proc_pipe_pkg;

  localparam logic [1:0] c_pc_sel_p4  = 2'd0;
  localparam logic [1:0] c_pc_sel_br  = 2'd1;
  localparam logic [1:0] c_pc_sel_jal = 2'd2;

  localparam logic [4:0] c_x0 = 5'd0;

  typedef struct packed {
    logic       val;
    logic       wen;
    logic [4:0] waddr;
  } stage_meta_t;

  // x0 is hardwired, so it never creates a dependency.
  function automatic logic raw_hit(input logic en, input logic [4:0] src, input stage_meta_t s);
    return en && (src != c_x0) && s.val && s.wen && (s.waddr == src);
  endfunction

endpackage

// File: rtl/lab2_proc_pipe_sequencer_if.sv
// Control bundle between the pipe sequencer (master) and the datapath (slave).
// Purely combinational wiring; no state or backpressure of its own.
interface lab2_proc_pipe_sequencer_if #(
  parameter int p_cnt_w = 32
);

  logic               imem_resp_val;
  logic               rs1_en_D;
  logic [4:0]         rs1_addr_D;
  logic               rs2_en_D;
  logic [4:0]         rs2_addr_D;
  logic               rf_wen_D;
  logic [4:0]         rf_waddr_D;
  logic               jal_D;
  logic               ostall_D;
  logic               br_taken_X;
  logic               ostall_X;
  logic               ostall_M;
  logic               ostall_W;
  logic               stats_en;

  logic               reg_en_F;
  logic               reg_en_D;
  logic               reg_en_X;
  logic               reg_en_M;
  logic               reg_en_W;
  logic [1:0]         pc_sel_F;
  logic               imem_respstream_drop;
  logic               val_X;
  logic               val_M;
  logic               val_W;
  logic               rf_wen_W;
  logic [4:0]         rf_waddr_W;
  logic [p_cnt_w-1:0] num_insts;
  logic [p_cnt_w-1:0] num_cycles;

  modport master (
    input  imem_resp_val, rs1_en_D, rs1_addr_D, rs2_en_D, rs2_addr_D,
           rf_wen_D, rf_waddr_D, jal_D, ostall_D, br_taken_X,
           ostall_X, ostall_M, ostall_W, stats_en,
    output reg_en_F, reg_en_D, reg_en_X, reg_en_M, reg_en_W, pc_sel_F,
           imem_respstream_drop, val_X, val_M, val_W, rf_wen_W, rf_waddr_W,
           num_insts, num_cycles
  );

  modport slave (
    output imem_resp_val, rs1_en_D, rs1_addr_D, rs2_en_D, rs2_addr_D,
           rf_wen_D, rf_waddr_D, jal_D, ostall_D, br_taken_X,
           ostall_X, ostall_M, ostall_W, stats_en,
    input  reg_en_F, reg_en_D, reg_en_X, reg_en_M, reg_en_W, pc_sel_F,
           imem_respstream_drop, val_X, val_M, val_W, rf_wen_W, rf_waddr_W,
           num_insts, num_cycles
  );

endinterface

// File: rtl/lab2_proc_pipe_sequencer_stage_meta.sv
// One pipeline slice of val/wen/waddr; loads on en_i, squash_i inserts a bubble.
// One-cycle register; holds its contents whenever en_i is low.
module lab2_proc_pipe_stage_meta
  import lab2_proc_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic        squash_i,
  input  stage_meta_t meta_i,
  output stage_meta_t meta_o
);

  stage_meta_t meta_q;
  stage_meta_t meta_d;

  always_comb begin
    meta_d = meta_q;
    if (en_i) begin
      meta_d.val   = meta_i.val & ~squash_i;
      meta_d.wen   = meta_i.wen & meta_d.val;
      meta_d.waddr = meta_i.waddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) meta_q <= '0;
    else       meta_q <= meta_d;
  end

  assign meta_o = meta_q;

endmodule

// File: rtl/lab2_proc_pipe_sequencer.sv
// F/D/X/M/W sequencer: stall chain, RAW interlock (no bypass), branch/jal squash, stats.
// Enables and pc_sel are combinational from current state; stalls propagate back toward F.
module lab2_proc_pipe_sequencer
  import lab2_proc_pipe_pkg::*;
#(
  parameter int p_cnt_w = 32
) (
  input logic                          clk,
  input logic                          reset,
  lab2_proc_pipe_sequencer_if.master   io
);

  logic               val_D_q, val_D_d;
  logic [p_cnt_w-1:0] num_insts_q, num_insts_d;
  logic [p_cnt_w-1:0] num_cycles_q, num_cycles_d;

  stage_meta_t meta_D, meta_X, meta_M, meta_W;

  logic raw_D;
  logic stall_F, stall_D, stall_X, stall_M, stall_W;
  logic squash_X, squash_D;
  logic reg_en_F, reg_en_D, reg_en_X, reg_en_M, reg_en_W;
  logic [1:0] pc_sel;

  // W is a hazard too: the regfile write lands after the same-cycle D read.
  assign raw_D = raw_hit(io.rs1_en_D, io.rs1_addr_D, meta_X)
               | raw_hit(io.rs1_en_D, io.rs1_addr_D, meta_M)
               | raw_hit(io.rs1_en_D, io.rs1_addr_D, meta_W)
               | raw_hit(io.rs2_en_D, io.rs2_addr_D, meta_X)
               | raw_hit(io.rs2_en_D, io.rs2_addr_D, meta_M)
               | raw_hit(io.rs2_en_D, io.rs2_addr_D, meta_W);

  assign stall_W = meta_W.val & io.ostall_W;
  assign stall_M = (meta_M.val & io.ostall_M) | stall_W;
  assign stall_X = (meta_X.val & io.ostall_X) | stall_M;
  assign stall_D = (val_D_q & (raw_D | io.ostall_D)) | stall_X;
  assign stall_F = ~io.imem_resp_val | stall_D;

  assign squash_X = meta_X.val & io.br_taken_X;
  assign squash_D = val_D_q & io.jal_D & ~stall_D & ~squash_X;

  always_comb begin
    pc_sel = c_pc_sel_p4;
    if (squash_X)      pc_sel = c_pc_sel_br;
    else if (squash_D) pc_sel = c_pc_sel_jal;
  end

  assign reg_en_F = ~stall_F | squash_X | squash_D;
  assign reg_en_D = ~stall_D | squash_X;
  assign reg_en_X = ~stall_X;
  assign reg_en_M = ~stall_M;
  assign reg_en_W = ~stall_W;

  assign val_D_d = reg_en_D ? (io.imem_resp_val & ~stall_F & ~squash_X & ~squash_D) : val_D_q;

  assign meta_D.val   = val_D_q;
  assign meta_D.wen   = io.rf_wen_D;
  assign meta_D.waddr = io.rf_waddr_D;

  lab2_proc_pipe_stage_meta u_meta_X (
    .clk      (clk),
    .reset    (reset),
    .en_i     (reg_en_X),
    .squash_i (stall_D | squash_X),
    .meta_i   (meta_D),
    .meta_o   (meta_X)
  );

  lab2_proc_pipe_stage_meta u_meta_M (
    .clk      (clk),
    .reset    (reset),
    .en_i     (reg_en_M),
    .squash_i (stall_X),
    .meta_i   (meta_X),
    .meta_o   (meta_M)
  );

  lab2_proc_pipe_stage_meta u_meta_W (
    .clk      (clk),
    .reset    (reset),
    .en_i     (reg_en_W),
    .squash_i (stall_M),
    .meta_i   (meta_M),
    .meta_o   (meta_W)
  );

  always_comb begin
    num_cycles_d = num_cycles_q;
    num_insts_d  = num_insts_q;
    if (io.stats_en) begin
      num_cycles_d = num_cycles_q + p_cnt_w'(1);
      if (meta_W.val & ~stall_W) num_insts_d = num_insts_q + p_cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_D_q      <= 1'b0;
      num_insts_q  <= '0;
      num_cycles_q <= '0;
    end else begin
      val_D_q      <= val_D_d;
      num_insts_q  <= num_insts_d;
      num_cycles_q <= num_cycles_d;
    end
  end

  assign io.reg_en_F             = reg_en_F;
  assign io.reg_en_D             = reg_en_D;
  assign io.reg_en_X             = reg_en_X;
  assign io.reg_en_M             = reg_en_M;
  assign io.reg_en_W             = reg_en_W;
  assign io.pc_sel_F             = pc_sel;
  assign io.imem_respstream_drop = squash_X | squash_D;
  assign io.val_X                = meta_X.val;
  assign io.val_M                = meta_M.val;
  assign io.val_W                = meta_W.val;
  assign io.rf_wen_W             = meta_W.val & meta_W.wen & ~stall_W;
  assign io.rf_waddr_W           = meta_W.waddr;
  assign io.num_insts            = num_insts_q;
  assign io.num_cycles           = num_cycles_q;

endmodule

// File: tb/tb_lab2_proc_pipe_sequencer.sv
// Directed bench for lab2_proc_pipe_sequencer: hand-scheduled instruction streams, immediate asserts.
module tb_lab2_proc_pipe_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  lab2_proc_pipe_sequencer_if #(.p_cnt_w(32)) io ();

  lab2_proc_pipe_sequencer #(.p_cnt_w(32)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    io.imem_resp_val = 1'b0;
    io.rs1_en_D      = 1'b0;
    io.rs1_addr_D    = 5'd0;
    io.rs2_en_D      = 1'b0;
    io.rs2_addr_D    = 5'd0;
    io.rf_wen_D      = 1'b0;
    io.rf_waddr_D    = 5'd0;
    io.jal_D         = 1'b0;
    io.ostall_D      = 1'b0;
    io.br_taken_X    = 1'b0;
    io.ostall_X      = 1'b0;
    io.ostall_M      = 1'b0;
    io.ostall_W      = 1'b0;
  endtask

  task automatic set_d(input logic wen, input logic [4:0] wa, input logic r1en,
                       input logic [4:0] r1, input logic jal);
    io.rf_wen_D   = wen;
    io.rf_waddr_D = wa;
    io.rs1_en_D   = r1en;
    io.rs1_addr_D = r1;
    io.jal_D      = jal;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clr_in();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    io.stats_en = 1'b0;
    clr_in();
    tick();
    tick();

    // reset state
    chk("rst_val_X", io.val_X, 1'b0);
    chk("rst_val_M", io.val_M, 1'b0);
    chk("rst_val_W", io.val_W, 1'b0);
    chk("rst_rf_wen_W", io.rf_wen_W, 1'b0);
    chk("rst_pc_sel", io.pc_sel_F, 2'd0);
    chk("rst_drop", io.imem_respstream_drop, 1'b0);
    chk("rst_num_insts", io.num_insts, 32'd0);
    chk("rst_num_cycles", io.num_cycles, 32'd0);
    reset = 1'b0;

    // independent stream of 5
    io.stats_en = 1'b1;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      clr_in();
      io.imem_resp_val = (k < 5);
      if (k >= 1 && k <= 5) set_d(1'b1, 5'(k), 1'b0, 5'd0, 1'b0);
      #1;
      chk("t1_en_D", io.reg_en_D, 1'b1);
      chk("t1_en_M", io.reg_en_M, 1'b1);
      chk("t1_val_W", io.val_W, (k >= 4));
      if (k >= 4) chk("t1_waddr_W", io.rf_waddr_W, 32'(k - 3));
      tick();
    end
    chk("t1_num_insts", io.num_insts, 32'd5);

    // RAW on x3: 3-cycle interlock
    do_reset();
    clr_in(); io.imem_resp_val = 1'b1; #1; tick();
    clr_in(); io.imem_resp_val = 1'b1; set_d(1'b1, 5'd3, 1'b0, 5'd0, 1'b0); #1;
    chk("t2_prod_en_D", io.reg_en_D, 1'b1);
    tick();
    for (int k = 2; k <= 4; k++) begin
      clr_in(); set_d(1'b0, 5'd0, 1'b1, 5'd3, 1'b0); #1;
      chk("t2_stall_en_D", io.reg_en_D, 1'b0);
      chk("t2_stall_en_X", io.reg_en_X, 1'b1);
      if (k > 2) chk("t2_bubble_val_X", io.val_X, 1'b0);
      if (k == 4) chk("t2_rf_wen_W", io.rf_wen_W, 1'b1);
      tick();
    end
    clr_in(); set_d(1'b0, 5'd0, 1'b1, 5'd3, 1'b0); #1;
    chk("t2_release_en_D", io.reg_en_D, 1'b1);
    chk("t2_release_val_X", io.val_X, 1'b0);
    tick();
    clr_in(); #1;
    chk("t2_cons_val_X", io.val_X, 1'b1);

    // x0 never interlocks
    do_reset();
    clr_in(); io.imem_resp_val = 1'b1; #1; tick();
    clr_in(); io.imem_resp_val = 1'b1; set_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1; tick();
    clr_in(); set_d(1'b0, 5'd0, 1'b1, 5'd0, 1'b0); #1;
    chk("t3_x0_en_D", io.reg_en_D, 1'b1);
    tick();
    clr_in(); #1;
    chk("t3_x0_val_X", io.val_X, 1'b1);

    // taken branch in X squashes D and F
    do_reset();
    clr_in(); io.imem_resp_val = 1'b1; #1; tick();
    clr_in(); io.imem_resp_val = 1'b1; #1; tick();
    clr_in(); io.imem_resp_val = 1'b1; io.br_taken_X = 1'b1; #1;
    chk("t4_pc_sel", io.pc_sel_F, 2'd1);
    chk("t4_drop", io.imem_respstream_drop, 1'b1);
    chk("t4_en_F", io.reg_en_F, 1'b1);
    chk("t4_en_D", io.reg_en_D, 1'b1);
    tick();
    clr_in(); #1;
    chk("t4_val_X_killed", io.val_X, 1'b0);
    chk("t4_val_M_br", io.val_M, 1'b1);
    tick();
    #1;
    chk("t4_val_X_F_killed", io.val_X, 1'b0);
    chk("t4_val_W_br", io.val_W, 1'b1);
    tick();
    #1;
    chk("t4_val_W_bubble", io.val_W, 1'b0);

    // jal in D with branch in X: branch wins; then jal alone
    do_reset();
    clr_in(); io.imem_resp_val = 1'b1; #1; tick();
    clr_in(); io.imem_resp_val = 1'b1; #1; tick();
    clr_in(); io.imem_resp_val = 1'b1; io.br_taken_X = 1'b1; set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b1); #1;
    chk("t5_both_pc_sel", io.pc_sel_F, 2'd1);
    chk("t5_both_drop", io.imem_respstream_drop, 1'b1);
    tick();
    clr_in(); io.imem_resp_val = 1'b1; #1;
    chk("t5_jal_killed", io.val_X, 1'b0);
    tick();
    clr_in(); io.imem_resp_val = 1'b1; set_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b1); #1;
    chk("t5_jal_pc_sel", io.pc_sel_F, 2'd2);
    chk("t5_jal_drop", io.imem_respstream_drop, 1'b1);
    chk("t5_jal_en_F", io.reg_en_F, 1'b1);
    tick();
    clr_in(); #1;
    chk("t5_jal_val_X", io.val_X, 1'b1);
    tick();
    #1;
    chk("t5_jal_F_killed", io.val_X, 1'b0);

    // ostall_M for 4 cycles with a full pipe
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      clr_in();
      io.imem_resp_val = (k <= 7);
      io.ostall_M      = (k >= 3 && k <= 6);
      if (k >= 1 && k <= 2)      set_d(1'b1, 5'(k), 1'b0, 5'd0, 1'b0);
      else if (k >= 3 && k <= 7) set_d(1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
      else if (k == 8)           set_d(1'b1, 5'd4, 1'b0, 5'd0, 1'b0);
      #1;
      if (k >= 3 && k <= 6) begin
        chk("t6_en_F", io.reg_en_F, 1'b0);
        chk("t6_en_X", io.reg_en_X, 1'b0);
        chk("t6_en_M", io.reg_en_M, 1'b0);
        chk("t6_en_W", io.reg_en_W, 1'b1);
      end
      if (k >= 4 && k <= 7) chk("t6_bubble_val_W", io.val_W, 1'b0);
      if (k >= 8 && k <= 11) begin
        chk("t6_val_W", io.val_W, 1'b1);
        chk("t6_waddr_W", io.rf_waddr_W, 32'(k - 7));
      end
      if (k == 12) chk("t6_num_insts", io.num_insts, 32'd4);
      tick();
    end

    // reset with every stage valid
    do_reset();
    for (int k = 0; k < 4; k++) begin
      clr_in(); io.imem_resp_val = 1'b1; #1; tick();
    end
    clr_in(); #1;
    chk("t7_full_val_X", io.val_X, 1'b1);
    chk("t7_full_val_M", io.val_M, 1'b1);
    chk("t7_full_val_W", io.val_W, 1'b1);
    chk("t7_cycles_pre", io.num_cycles, 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("t7_val_X", io.val_X, 1'b0);
    chk("t7_val_M", io.val_M, 1'b0);
    chk("t7_val_W", io.val_W, 1'b0);
    chk("t7_rf_wen_W", io.rf_wen_W, 1'b0);
    chk("t7_num_insts", io.num_insts, 32'd0);
    chk("t7_num_cycles", io.num_cycles, 32'd0);
    tick();
    #1;
    chk("t7_val_D_cleared", io.val_X, 1'b0);

    // stats_en gating: 10 on, 5 off
    io.stats_en = 1'b0;
    do_reset();
    io.stats_en = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("t8_cycles_on", io.num_cycles, 32'd10);
    io.stats_en = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("t8_cycles_off", io.num_cycles, 32'd10);
    chk("t8_insts", io.num_insts, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lab2_proc_pipe_sequencer.md
Name: lab2_proc_pipe_sequencer

Overview:
Pipeline sequencing controller for the 5-stage in-order processor datapath (F/D/X/M/W). It tracks per-stage valid bits and destination-register metadata. From these it generates stage register enables, stalls for RAW hazards with no bypassing, squashes on taken branches and jumps, and drives the PC-select mux and the imem drop signal. It also keeps retired-instruction and cycle counters, gated by stats_en. Instruction decode stays outside this block; it consumes pre-decoded D-stage fields.

Parameters:
p_cnt_w, 32, width of the instruction and cycle counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
imem_resp_val  in  1  F-stage instruction response valid
rs1_en_D  in  1  D instruction reads rs1
rs1_addr_D  in  5  rs1 index
rs2_en_D  in  1  D instruction reads rs2
rs2_addr_D  in  5  rs2 index
rf_wen_D  in  1  D instruction writes rd
rf_waddr_D  in  5  rd index
jal_D  in  1  D instruction is jal
ostall_D  in  1  D-local stall (e.g. mngr2proc not valid)
br_taken_X  in  1  X branch resolved taken
ostall_X  in  1  dmem request not ready
ostall_M  in  1  dmem response not valid
ostall_W  in  1  proc2mngr not ready
stats_en  in  1  counter enable
reg_en_F, reg_en_D, reg_en_X, reg_en_M, reg_en_W  out  1 each  stage register enables
pc_sel_F  out  2  0 = pc+4, 1 = br_target_X, 2 = jal_target_D
imem_respstream_drop  out  1  discard current imem response
val_X, val_M, val_W  out  1 each  stage valid
rf_wen_W  out  1  regfile write enable (val_W & wen_W & !stall_W)
rf_waddr_W  out  5  regfile write index
num_insts  out  p_cnt_w  retired instructions
num_cycles  out  p_cnt_w  cycles with stats_en high

Behaviour:
- Reset: val_D/X/M/W = 0, wen_X/M/W = 0, waddr_X/M/W = 0, counters = 0. Hence rf_wen_W = 0, pc_sel_F = 0, drop = 0.
- Stall chain:
  - stall_W = val_W & ostall_W
  - stall_M = val_M & ostall_M | stall_W
  - stall_X = val_X & ostall_X | stall_M
  - stall_D = val_D & (raw_D | ostall_D) | stall_X
  - stall_F = !imem_resp_val | stall_D
- raw_D is true when an enabled rs1 or rs2 with index != 0 matches waddr in X, M or W, and that stage has val & wen. W counts as a hazard because the regfile write is not visible to the same-cycle read.
- Squash priorities:
  - squash_X = val_X & br_taken_X. Kills D and F; pc_sel_F = 1.
  - Otherwise, squash_D = val_D & jal_D & !stall_D. Kills F; pc_sel_F = 2.
  - Otherwise pc_sel_F = 0.
- imem_respstream_drop = squash_X | squash_D.
- Enables:
  - reg_en_F = !stall_F | squash_X | squash_D
  - reg_en_D = !stall_D | squash_X
  - reg_en_X = !stall_X
  - reg_en_M = !stall_M
  - reg_en_W = !stall_W
- Valid updates (each stage holds when its enable is low):
  - val_D <= imem_resp_val & !stall_F & !squash_X & !squash_D
  - val_X <= val_D & !stall_D & !squash_X (bubble on stall)
  - val_M <= val_X & !stall_X
  - val_W <= val_M & !stall_M
- wen/waddr advance with the valid bits. wen is cleared whenever val is cleared.
- When squash_X and a stalled D occur together, the squash wins: D is cleared.
- Counters:
  - num_cycles += 1 each cycle stats_en = 1.
  - num_insts += 1 when stats_en & val_W & !stall_W.
  - Both wrap modulo 2^p_cnt_w.
- Reset asserted mid-operation clears all valid bits in the same edge; there is no partial drain.

Decomposition:
- Shared package lab2_proc_pipe_pkg holds:
  - pc_sel encodings c_pc_sel_p4 = 0, c_pc_sel_br = 1, c_pc_sel_jal = 2
  - c_x0 = 5'd0
- One natural sub-module, lab2_proc_pipe_stage_meta: a val/wen/waddr register slice with enable and squash. It is instantiated three times, for X, M and W.

Test Plan:
- Independent ALU stream, 5 instructions with distinct rd and no source overlap → first val_W at cycle 4 after first imem_resp_val; num_insts = 5; no stall or enable-low cycles.
- rd = x3 producer immediately followed by an rs1 = x3 consumer → D stalls 3 cycles (producer in X, M, W). reg_en_D = 0 for those cycles; val_X = 0 bubbles; the consumer then advances.
- Consumer reads x0 while a producer writes x0 → no stall.
- br_taken_X with valid instructions in D and F → pc_sel_F = 1, drop = 1, val_D = 0 and val_X = 0 next cycle; two bubbles reach W.
- jal_D at the same cycle as br_taken_X → pc_sel_F = 1; jal squashed.
- ostall_M held 4 cycles → reg_en_F/D/X/M = 0 for those 4 cycles; val_W = 0 bubbles; all state preserved; resumes without loss.
- Assert reset with all stages valid → next cycle all val = 0, rf_wen_W = 0, counters = 0.
- stats_en toggled 10 cycles on / 5 off → num_cycles = 10.
